// File: rtl/mp3src_rom_arb.sv
// mp3src_rom_arb: round-robin two-port arbiter for the MP3 source ROM; MP3SRC_ARB_STATS_EN adds grant/conflict/error counters
`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 10
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
module mp3src_rom_arb #(
  parameter int AW = `ADDRESS_WIDTH,
  parameter int DW = `DATA_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
`ifdef MP3SRC_ARB_STATS_EN
  output logic [31:0]   gnt_cnt0,
  output logic [31:0]   gnt_cnt1,
  output logic [31:0]   conflict_cnt,
  output logic [15:0]   err_cnt,
`endif
  input  logic [AW:0]   src_len,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          gnt0,
  output logic          rvalid0,
  output logic [DW-1:0] rdata0,
  output logic          rerr0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  output logic          gnt1,
  output logic          rvalid1,
  output logic [DW-1:0] rdata1,
  output logic          rerr1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data
);
  logic last_gnt, a_vld, a_port, a_oor;
  // grant: lone requester wins, a conflict goes to the port not granted last
  always_comb begin
    gnt0 = rst_n & req0 & (~req1 | last_gnt);
    gnt1 = rst_n & req1 & (~req0 | ~last_gnt);
    rom_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
  end
  // stage A: remember which port was granted and whether its address is past the stream
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_gnt <= 1'b1;
      a_vld <= 1'b0;
      a_port <= 1'b0;
      a_oor <= 1'b0;
    end else begin
      if (gnt0 | gnt1) last_gnt <= gnt1;
      a_vld <= gnt0 | gnt1;
      a_port <= gnt1;
      a_oor <= {1'b0, rom_addr} >= src_len;
    end
  end
  // stage B: route the ROM word to its requester; the idle port keeps its last data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      rerr0 <= 1'b0;
      rerr1 <= 1'b0;
    end else begin
      rvalid0 <= a_vld & ~a_port;
      rvalid1 <= a_vld & a_port;
      if (a_vld & ~a_port) begin
        rdata0 <= a_oor ? '0 : rom_data;
        rerr0 <= a_oor;
      end
      if (a_vld & a_port) begin
        rdata1 <= a_oor ? '0 : rom_data;
        rerr1 <= a_oor;
      end
    end
  end
`ifdef MP3SRC_ARB_STATS_EN
  // saturating event counters, each bumped on the edge closing the cycle of its event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
      conflict_cnt <= '0;
      err_cnt <= '0;
    end else begin
      gnt_cnt0 <= gnt_cnt0 + 32'(gnt0 & ~&gnt_cnt0);
      gnt_cnt1 <= gnt_cnt1 + 32'(gnt1 & ~&gnt_cnt1);
      conflict_cnt <= conflict_cnt + 32'(req0 & req1 & ~&conflict_cnt);
      err_cnt <= err_cnt + 16'(((rvalid0 & rerr0) | (rvalid1 & rerr1)) & ~&err_cnt);
    end
  end
`endif
endmodule

// File: tb/tb_mp3src_rom_arb.sv
// tb_mp3src_rom_arb: randomized and directed checks of the ROM arbiter against a queue-based response model
module tb_mp3src_rom_arb;
  localparam int AW = 10;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [AW:0] src_len = 11'd1024;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1;
  logic [DW-1:0] rdata0, rdata1, rom_data;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int errors = 0, checks = 0;
`ifdef MP3SRC_ARB_STATS_EN
  logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
  logic [15:0] err_cnt;
`endif

  mp3src_rom_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef MP3SRC_ARB_STATS_EN
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1), .conflict_cnt(conflict_cnt), .err_cnt(err_cnt),
`endif
    .src_len(src_len),
    .req0(req0), .addr0(addr0), .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0), .rerr0(rerr0),
    .req1(req1), .addr1(addr1), .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1), .rerr1(rerr1),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= mem[rom_addr];

  typedef struct {int due; int port; logic [DW-1:0] d; logic e;} rsp_t;
  rsp_t q[$];
  int cyc = 0, m_last = 1, w = -1;
  logic [DW-1:0] pd0 = '0, pd1 = '0;
  logic pe0 = 1'b0, pe1 = 1'b0;

  always @(negedge clk) begin
    logic [1:0] eg, ev;
    logic [AW-1:0] ea;
    w = !rst_n ? -1 : (req0 && req1) ? 1 - m_last : req0 ? 0 : req1 ? 1 : -1;
    eg = w == 0 ? 2'b01 : w == 1 ? 2'b10 : 2'b00;
    ea = w == 0 ? addr0 : w == 1 ? addr1 : '0;
    checks++;
    if ({gnt1, gnt0} !== eg || rom_addr !== ea) begin
      errors++;
      $display("FAIL grant cyc=%0d: gnt=%b addr=%0d want gnt=%b addr=%0d", cyc, {gnt1, gnt0}, rom_addr, eg, ea);
    end
    ev = 2'b00;
    if (q.size() > 0 && q[0].due == cyc) begin
      ev[q[0].port] = 1'b1;
      if (q[0].port == 0) begin pd0 = q[0].d; pe0 = q[0].e; end
      else begin pd1 = q[0].d; pe1 = q[0].e; end
      void'(q.pop_front());
    end
    checks++;
    if ({rvalid1, rvalid0} !== ev || rdata0 !== pd0 || rdata1 !== pd1 || rerr0 !== pe0 || rerr1 !== pe1) begin
      errors++;
      $display("FAIL response cyc=%0d: rvalid=%b d0=%h e0=%b d1=%h e1=%b want rvalid=%b d0=%h e0=%b d1=%h e1=%b",
               cyc, {rvalid1, rvalid0}, rdata0, rerr0, rdata1, rerr1, ev, pd0, pe0, pd1, pe1);
    end
  end

  always @(posedge clk) begin
    logic [AW-1:0] a;
    logic oor;
    if (!rst_n) begin
      q.delete();
      m_last = 1;
      pd0 = '0; pd1 = '0; pe0 = 1'b0; pe1 = 1'b0;
    end else if (w >= 0) begin
      a = w == 1 ? addr1 : addr0;
      oor = int'(a) >= int'(src_len);
      q.push_back('{cyc + 2, w, oor ? '0 : mem[a], oor});
      m_last = w;
    end
    cyc++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b0;
    tick; tick;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1; addr0 = 10'd7; addr1 = 10'd9;
    tick; tick;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1} !== 6'b0 || rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_state: gnt=%b%b rv=%b%b err=%b%b d0=%h d1=%h want all 0", gnt0, gnt1, rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1);
    end
    tick;
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
    tick;
  endtask

  task automatic test_single;
    src_len = 11'd1024; req0 = 1'b1; addr0 = 10'd5;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1 || rom_addr !== 10'd5) begin
      errors++;
      $display("FAIL single_grant: gnt0=%b rom_addr=%0d want 1 5", gnt0, rom_addr);
    end
    tick; req0 = 1'b0; tick;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== mem[5] || rerr0 !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: rvalid0=%b rdata0=%h rerr0=%b want 1 %h 0", rvalid0, rdata0, rerr0, mem[5]);
    end
    tick; tick;
  endtask

  task automatic test_conflict;
    do_reset;
    src_len = 11'd1024; req0 = 1'b1; req1 = 1'b1;
    addr0 = 10'($urandom_range(0, 1023)); addr1 = 10'($urandom_range(0, 1023));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (gnt0 !== 1'(i % 2 == 0) || gnt1 !== 1'(i % 2 == 1)) begin
        errors++;
        $display("FAIL conflict_order %0d: gnt0=%b gnt1=%b want %b %b", i, gnt0, gnt1, 1'(i % 2 == 0), 1'(i % 2 == 1));
      end
      if (i >= 2) begin
        checks++;
        if (rvalid0 !== 1'(i % 2 == 0) || rvalid1 !== 1'(i % 2 == 1)) begin
          errors++;
          $display("FAIL conflict_resp %0d: rvalid0=%b rvalid1=%b", i, rvalid0, rvalid1);
        end
      end
      tick;
      if (i % 2 == 0) addr0 = 10'($urandom_range(0, 1023));
      else addr1 = 10'($urandom_range(0, 1023));
    end
    req0 = 1'b0; req1 = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_oor;
    src_len = 11'd100; req1 = 1'b1; addr1 = 10'd99;
    tick;
    addr1 = 10'd100;
    tick;
    req1 = 1'b0;
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== mem[99] || rerr1 !== 1'b0) begin
      errors++;
      $display("FAIL oor_last_valid: rvalid1=%b rdata1=%h rerr1=%b want 1 %h 0", rvalid1, rdata1, rerr1, mem[99]);
    end
    tick;
    @(negedge clk);
    checks++;
    if (rvalid1 !== 1'b1 || rdata1 !== '0 || rerr1 !== 1'b1) begin
      errors++;
      $display("FAIL oor_first_bad: rvalid1=%b rdata1=%h rerr1=%b want 1 0 1", rvalid1, rdata1, rerr1);
    end
    src_len = '0; req0 = 1'b1; addr0 = 10'd0;
    tick; req0 = 1'b0; tick;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b1 || rdata0 !== '0 || rerr0 !== 1'b1) begin
      errors++;
      $display("FAIL oor_len0: rvalid0=%b rdata0=%h rerr0=%b want 1 0 1", rvalid0, rdata0, rerr0);
    end
    tick; src_len = 11'd1024; tick;
  endtask

  task automatic test_stream;
    src_len = 11'd1024;
    for (int i = 0; i < 10; i++) begin
      req1 = 1'(i < 8);
      addr1 = i < 8 ? 10'(i) : '0;
      if (i >= 2) begin
        @(negedge clk);
        checks++;
        if (rvalid1 !== 1'b1 || rdata1 !== mem[i-2] || rerr1 !== 1'b0) begin
          errors++;
          $display("FAIL stream %0d: rvalid1=%b rdata1=%h want 1 %h", i - 2, rvalid1, rdata1, mem[i-2]);
        end
      end
      tick;
    end
    tick;
  endtask

  task automatic test_reset_midflight;
    do_reset;
    src_len = 11'd1024; req0 = 1'b1; addr0 = 10'd3;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b1) begin
      errors++;
      $display("FAIL midflight_grant: gnt0=%b want 1", gnt0);
    end
    tick;
    rst_n = 1'b0; req1 = 1'b1;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL midflight_in_reset: gnt0=%b gnt1=%b rvalid0=%b want 0 0 0", gnt0, gnt1, rvalid0);
    end
    tick;
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, rerr0, rerr1} !== 4'b0 || rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL midflight_cleared: rv=%b%b err=%b%b d0=%h d1=%h want all 0", rvalid0, rvalid1, rerr0, rerr1, rdata0, rdata1);
    end
    tick;
    req0 = 1'b1; req1 = 1'b1; addr1 = 10'd4;
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL midflight_after: rvalid0=%b gnt0=%b gnt1=%b want 0 1 0", rvalid0, gnt0, gnt1);
    end
    tick;
    req0 = 1'b0; req1 = 1'b0;
    tick; tick; tick;
  endtask

  task automatic test_random;
    logic g0, g1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      g0 = gnt0; g1 = gnt1;
      tick;
      rst_n = $urandom_range(0, 59) != 0;
      if (i % 25 == 0) src_len = 11'($urandom_range(0, 40));
      if (req0 && !g0) begin
        if ($urandom_range(0, 5) == 0) req0 = 1'b0;
      end else begin
        req0 = 1'($urandom_range(0, 1)); addr0 = 10'($urandom_range(0, 45));
      end
      if (req1 && !g1) begin
        if ($urandom_range(0, 5) == 0) req1 = 1'b0;
      end else begin
        req1 = 1'($urandom_range(0, 1)); addr1 = 10'($urandom_range(0, 45));
      end
    end
    req0 = 1'b0; req1 = 1'b0; rst_n = 1'b1;
    tick; tick; tick;
  endtask

`ifdef MP3SRC_ARB_STATS_EN
  task automatic test_stats;
    test_conflict;
    src_len = '0; req1 = 1'b1; addr1 = 10'd2;
    tick; tick;
    req1 = 1'b0;
    tick; tick; tick;
    checks++;
    if (gnt_cnt0 !== 32'd3 || gnt_cnt1 !== 32'd5 || conflict_cnt !== 32'd6 || err_cnt !== 16'd2) begin
      errors++;
      $display("FAIL stats: g0=%0d g1=%0d conf=%0d err=%0d want 3 5 6 2", gnt_cnt0, gnt_cnt1, conflict_cnt, err_cnt);
    end
    src_len = 11'd1024;
  endtask
`endif

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    test_reset;
    test_single;
    test_conflict;
    test_oor;
    test_stream;
    test_reset_midflight;
`ifdef MP3SRC_ARB_STATS_EN
    test_stats;
`endif
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mp3src_rom_arb.md
Name: mp3src_rom_arb

Overview:
- Two-port round-robin arbiter and sequencer in front of the single-port MP3 source ROM (1-cycle registered read).
- Shares the ROM between the frame-header/side-info parser (port 0) and the main-data bit reservoir fetcher (port 1).
- Accepts one read per cycle, tracks in-flight reads, and routes each returned word to its requester.
- Flags reads past the loaded stream length.

Parameters:
- AW, `ADDRESS_WIDTH: ROM word-address width.
- DW, `DATA_WIDTH: ROM word width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- src_len  in  AW+1  number of valid words in ROM; quasi-static, sampled every cycle.
- req0  in  1  port 0 read request; held until gnt0.
- addr0  in  AW  port 0 word address; stable while req0 is high.
- gnt0  out  1  port 0 request accepted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (registered).
- rdata0  out  DW  port 0 read data.
- rerr0  out  1  port 0 out-of-range read, qualified by rvalid0.
- req1, addr1, gnt1, rvalid1, rdata1, rerr1: as port 0, for port 1.
- rom_addr  out  AW  to ROM addr (combinational mux).
- rom_data  in  DW  from ROM data; valid one cycle after rom_addr is sampled.

Behaviour:
- Grant rules:
  - At most one grant per cycle.
  - Single requester: granted in the same cycle.
  - Both requesting: grant the port not granted most recently.
  - last_gnt updates only on a grant. Reset value is 1, so port 0 wins the first conflict.
  - No request: no grant, rom_addr = 0.
- Address mux: rom_addr = addr of granted port, else 0.
- Pipeline (grant in cycle T):
  - Stage A register, edge ending T: {vld, port, oor}, where oor = (addr >= src_len). The comparison is AW+1 bits wide, zero-extending addr.
  - T+1: rom_data is valid. Stage B register captures rom_data, gated to 0 when oor.
  - T+2: rvalid<port>=1 for exactly one cycle. rdata = ROM word, or 0 when out of range. rerr = oor.
- Latency and ordering:
  - Fixed latency of 2 cycles from gnt to rvalid.
  - Throughput is 1 read/cycle aggregate.
  - Responses per port return in request order.
  - The non-addressed port's rvalid is 0 and its rdata/rerr hold their previous values.
- src_len = 0: every read returns rerr=1, rdata=0.
- addr = src_len-1: in range. addr = src_len: error.
- Reset (rst_n=0 at a posedge):
  - Both pipeline stages cleared; in-flight reads are dropped, and no rvalid appears in the 2 cycles after reset.
  - rvalid0/1=0, rdata0/1=0, rerr0/1=0, last_gnt=1.
  - gnt0/1 are forced 0 while rst_n=0.
- Requester contract:
  - Deasserting req before grant is legal: the request is withdrawn with no side effects.
  - A port may re-request in the cycle after its grant.

Optional Feature:
- Macro: MP3SRC_ARB_STATS_EN.
- When defined, adds outputs:
  - gnt_cnt0 (32): counts gnt0.
  - gnt_cnt1 (32): counts gnt1.
  - conflict_cnt (32): counts cycles with req0&req1.
  - err_cnt (16): counts rvalid with rerr.
- All counters saturate at all-ones, reset to 0, and increment on the same edge as the event.
- When not defined: these ports and their logic are absent, and arbitration behaviour is identical.

Test Plan:
- Single port read: src_len=1024, req0 with addr0=5 in cycle 10. Expect gnt0 in cycle 10, rom_addr=5, rvalid0 in cycle 12 with rdata0=mem[5], rerr0=0.
- Conflict alternation: req0 and req1 both held high from reset release for 6 grants. Expect grant order 0,1,0,1,0,1 and responses back-to-back on alternating ports, 2 cycles after each grant.
- Out of range: src_len=100, addr1=99 then addr1=100. Expect rerr1=0 with data mem[99], then rerr1=1 with rdata1=0. With src_len=0, addr0=0 gives rerr0=1.
- Streaming: req1 high for 8 cycles, addr1=0..7. Expect 8 consecutive rvalid1 with rdata1=mem[0..7] in order, no bubbles.
- Reset mid-flight: grant addr0=3 in cycle T, rst_n=0 at the edge ending T+1. Expect no rvalid0 in cycles T+1..T+3, all outputs 0, and the next conflict after reset granted to port 0.
- Stats (MP3SRC_ARB_STATS_EN): run the conflict scenario plus 2 out-of-range reads. Expect gnt_cnt0=3+k and gnt_cnt1=3+(2−k), where k is the number of out-of-range reads issued on port 0. Expect conflict_cnt=6 and err_cnt=2.
